counter: RTL and testbench

COUNTER -- requirements
Module: counter

---
 rtl/counter.sv | 25 ++
 tb/tb_counter.sv | 92 +++++++++
 2 files changed

// File: rtl/counter.sv
// counter: free-running modulo counter with a parameterised step and reset value.
// The sum is 8 bits wide, so any q + STEP below 2*MODULUS wraps with a single subtract.
module counter #(
   parameter int MODULUS     = 128,
   parameter int STEP        = 1,
   parameter int RESET_VALUE = 0
) (
   input  logic       clk,
   input  logic       reset,
   output logic [6:0] q
);
   localparam logic [7:0] MOD     = 8'(MODULUS);
   localparam logic [7:0] STP     = 8'(STEP);
   localparam logic [6:0] RST_VAL = 7'(RESET_VALUE);
   logic [6:0] q_q, q_d;
   logic [7:0] sum;
   always_comb begin
      sum = {1'b0, q_q} + STP;
      q_d = sum >= MOD ? 7'(sum - MOD) : sum[6:0];
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) q_q <= RST_VAL;
      else       q_q <= q_d;
   assign q = q_q;
endmodule

// File: tb/tb_counter.sv
// tb_counter: drives three counter variants from one clock and reset and checks them
// against a scoreboard of expected counts.
module tb_counter;
   logic clk = 1'b0;
   logic reset;
   logic [6:0] q_d, q_m, q_r;
   typedef struct {int d; int m; int r;} exp_t;
   exp_t sb[$];
   int ed, em, er;
   int passed = 0;
   int total = 0;

   always #10 clk = ~clk;

   counter dut_d (.clk(clk), .reset(reset), .q(q_d));
   counter #(.MODULUS(10), .STEP(3)) dut_m (.clk(clk), .reset(reset), .q(q_m));
   counter #(.RESET_VALUE(100)) dut_r (.clk(clk), .reset(reset), .q(q_r));

   task automatic chk(input string tag, input int act, input int exp);
      total++;
      assert (act === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
   endtask

   task automatic model_reset();
      ed = 0;
      em = 0;
      er = 100;
   endtask

   task automatic check_all(input string tag, input exp_t e);
      chk({tag, " def"}, int'(q_d), e.d);
      chk({tag, " m10"}, int'(q_m), e.m);
      chk({tag, " rv100"}, int'(q_r), e.r);
      chk({tag, " m10 range"}, int'(q_m < 7'd10), 1);
   endtask

   // one clock edge: push the expected post-edge counts, then compare after the edge
   task automatic step(input string tag);
      exp_t e;
      if (!reset) begin
         ed = (ed + 1) % 128;
         em = (em + 3) % 10;
         er = (er + 1) % 128;
      end
      sb.push_back('{ed, em, er});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check_all(tag, e);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0;
      #1 reset = 1'b1;
      model_reset();
      #4 check_all("reset", '{ed, em, er});
      step("reset hold");
      #9 reset = 1'b0;
      for (int k = 1; k <= 4; k++) step("basic");
      for (int k = 5; k <= 37; k++) step("to37");
      chk("reached 37", int'(q_d), 37);
      #5 reset = 1'b1;
      model_reset();
      #1 check_all("async reset", '{ed, em, er});
      for (int k = 0; k < 3; k++) step("reset held");
      #5 reset = 1'b0;
      for (int k = 1; k <= 129; k++) begin
         step("run");
         if (k == 28) chk("rv100 wrap at 28", int'(q_r), 0);
         if (k == 127) chk("def reaches 127", int'(q_d), 127);
         if (k == 128) chk("def wraps to 0", int'(q_d), 0);
         if (k == 129) chk("def 1 after wrap", int'(q_d), 1);
      end
      #5 reset = 1'b1;
      model_reset();
      #1 check_all("reset again", '{ed, em, er});
      @(posedge clk);
      reset <= 1'b0;
      #1 check_all("coincident edge", '{ed, em, er});
      step("after coincident");
      chk("def 1 after coincident", int'(q_d), 1);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
